bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter. It is the successor to the team's single-digit decade counter.
- Adds digit cascading, up/down direction, enable, synchronous clear, parallel load, wrap/saturate mode, and terminal-count and overflow/underflow flags.
- Drives the board seven-segment display path: one BCD nibble per digit, least significant digit in bits [3:0].

Parameters:
- NUM_DIGITS, 4, number of cascaded BCD digits (legal range 1..8).
- WRAP_EN, 1, 1 = wrap at the limits, 0 = saturate at the limits.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable. Sampled each rising edge.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- load_val  in  4*NUM_DIGITS  value to load, BCD, digit i in bits [4i+3:4i].
- count  out  4*NUM_DIGITS  current BCD count, registered.
- tc  out  1  terminal count, combinational from count and up.
- ovf  out  1  overflow pulse, registered.
- unf  out  1  underflow pulse, registered.
- load_err  out  1  invalid-digit-on-load pulse, registered.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. While rst is high: count = 0, ovf = 0, unf = 0, load_err = 0. Reset asserted mid-count clears everything immediately, with no edge needed. The first count happens on the first rising edge after rst deasserts with en = 1.
- Priority per edge: clr > load > en. Lower-priority inputs are ignored in that cycle.
- clr = 1: count becomes 0 on the next edge. ovf, unf and load_err are 0.
- load = 1 (clr = 0): each digit takes load_val[4i+3:4i].
  - Any nibble greater than 9 is clamped to 9, and load_err = 1 for exactly that one cycle.
  - ovf and unf are 0.
- en = 1, up = 1: digit 0 increments.
  - A digit at 9 wraps to 0 and passes a carry to the next digit.
  - A digit increments only if all lower digits are 9 (ripple carry, resolved within one cycle).
  - At all-9s (e.g. 9999 for NUM_DIGITS = 4):
    - WRAP_EN = 1: next count = 0.
    - WRAP_EN = 0: count holds at all-9s.
    - In both modes ovf = 1 for one cycle.
- en = 1, up = 0: digit 0 decrements.
  - A digit at 0 goes to 9 and passes a borrow to the next digit.
  - At all-0s:
    - WRAP_EN = 1: next count = all-9s.
    - WRAP_EN = 0: count holds at 0.
    - In both modes unf = 1 for one cycle.
- en = 0, with no clr and no load: count holds; all pulse outputs are 0.
- Pulse timing:
  - ovf, unf and load_err are registered. They are high in the same cycle that the new count value appears, and low in every other cycle.
  - They never assert together.
- tc:
  - tc = 1 when up = 1 and count == all-9s, or when up = 0 and count == 0.
  - tc is independent of en, clr and load. It follows a change of up in the same cycle.
- Direction change: a change of up takes effect on the next edge. There is no pipeline or latency penalty.
- Latency: one cycle from input to count for every operation.
- Invariant: the counter never holds a non-BCD nibble, whatever sequence is applied.

Test Plan:
- Reset and up-count (N = 4, wrap): rst pulse, en = 1, up = 1 for 12 cycles -> count 0000 through 0012 in BCD. The 0009 -> 0010 step shows the carry; tc = 0 throughout.
- Wrap overflow: load 9998, up = 1, en = 1 for 3 cycles -> 9999 with tc = 1, then 0000 with ovf = 1 for one cycle, then 0001 with ovf = 0.
- Saturate underflow (WRAP_EN = 0): load 0001, up = 0, en = 1 for 3 cycles -> 0000, then 0000 with unf = 1, then 0000 with unf = 1. With up = 0 at 0000, tc = 1.
- Priority and load error: clr = 1, load = 1, en = 1 together -> count 0000. Next cycle load = 1 with load_val = 0x3A7F -> count 3979, load_err = 1 for that cycle only.
- Borrow chain: load 1000, up = 0, en = 1 for one cycle -> 0999. Toggle up = 1 for one cycle -> 1000.
- Async reset mid-operation: assert rst between edges while counting at 0456 -> count 0000 before the next edge. Release rst with en = 1 -> 0001 on the first subsequent edge.

Source files
------------

// File: rtl/bcd_updown_counter_if.sv
// Bus bundle for bcd_updown_counter: control inputs, parallel load value,
// BCD count and the status outputs.
interface bcd_updown_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up;
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    tc;
  logic                    ovf;
  logic                    unf;
  logic                    load_err;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tc, ovf, unf, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tc, ovf, unf, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit cascaded BCD up/down counter with clear, load (digit clamping),
// wrap/saturate limits, terminal count and overflow/underflow/load-error pulses.
module bcd_updown_counter #(
  parameter int NUM_DIGITS = 4,
  parameter bit WRAP_EN    = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_updown_counter_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         err_q, err_d;

  logic [W-1:0] step_val;
  logic [W-1:0] load_clamped;
  logic         ripple;
  logic         any_bad;

  // Carry/borrow ripples through every digit in one cycle; a ripple surviving
  // past the top digit means the count sat at its limit (all-9s up, all-0s down).
  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so the loop reads updated values and no latch is inferred.
  always_comb begin
    step_val = count_q;
    ripple   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ripple) begin
        if (bus.up) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_clamped = bus.load_val;
    any_bad      = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
        any_bad                = 1'b1;
      end
    end
  end

  // Priority clr > load > en; pulses are computed alongside the new count so
  // they appear in the same cycle as the value that caused them.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    err_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = load_clamped;
      err_d   = any_bad;
    end else if (bus.en) begin
      if (!(ripple && !WRAP_EN)) begin
        count_d = step_val;
      end
      ovf_d = ripple & bus.up;
      unf_d = ripple & ~bus.up;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.up ? (count_q == ALL_NINES) : (count_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a wrapping and a saturating 4-digit counter share stimulus
// and are compared against an integer-arithmetic reference model.
module tb_bcd_updown_counter;
  localparam int MAXV = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.NUM_DIGITS(4)) ifw ();
  bcd_updown_counter_if #(.NUM_DIGITS(4)) ifs ();

  bcd_updown_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .bus(ifw.slave));
  bcd_updown_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .bus(ifs.slave));

  typedef struct packed {
    logic [15:0] cnt_w;
    logic [15:0] cnt_s;
    logic [2:0]  flg_w;  // {ovf, unf, load_err}
    logic [2:0]  flg_s;
    logic        tc_w;
    logic        tc_s;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int mw = 0, ms = 0;   // model values for the wrap and saturate instances
  int pw = 0, ps = 0;   // model values before the latest drive

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic tc_ref(input int v, input logic u);
    return u ? (v == MAXV) : (v == 0);
  endfunction

  function automatic void model_step(input int v, input bit wrap, input logic e, input logic u,
                                     input logic c, input logic l, input logic [15:0] lv,
                                     output int nv, output logic [2:0] f);
    int d;
    nv = v;
    f  = 3'b000;
    if (c) begin
      nv = 0;
    end else if (l) begin
      nv = 0;
      for (int i = 3; i >= 0; i--) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) begin
          d = 9;
          f[0] = 1'b1;
        end
        nv = nv * 10 + d;
      end
    end else if (e) begin
      if (u) begin
        if (v == MAXV) begin
          f[2] = 1'b1;
          nv = wrap ? 0 : MAXV;
        end else nv = v + 1;
      end else begin
        if (v == 0) begin
          f[1] = 1'b1;
          nv = wrap ? MAXV : 0;
        end else nv = v - 1;
      end
    end
  endfunction

  // Apply inputs at the falling edge and queue the response due after the next rising edge.
  task automatic drive(input logic e, input logic u, input logic c, input logic l, input logic [15:0] lv);
    exp_t x;
    int nw, ns;
    logic [2:0] fw, fs;
    @(negedge clk);
    rst = 1'b0;
    ifw.en = e; ifw.up = u; ifw.clr = c; ifw.load = l; ifw.load_val = lv;
    ifs.en = e; ifs.up = u; ifs.clr = c; ifs.load = l; ifs.load_val = lv;
    pw = mw;
    ps = ms;
    model_step(mw, 1'b1, e, u, c, l, lv, nw, fw);
    model_step(ms, 1'b0, e, u, c, l, lv, ns, fs);
    mw = nw;
    ms = ns;
    x.cnt_w = to_bcd(mw); x.cnt_s = to_bcd(ms);
    x.flg_w = fw;         x.flg_s = fs;
    x.tc_w  = tc_ref(mw, u);
    x.tc_s  = tc_ref(ms, u);
    q.push_back(x);
  endtask

  task automatic step(input logic e, input logic u, input logic c, input logic l, input logic [15:0] lv);
    drive(e, u, c, l, lv);
    @(posedge clk);
  endtask

  // Monitor: every registered output update is compared against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("wrap_count", 32'(ifw.count), 32'(x.cnt_w));
        check("sat_count",  32'(ifs.count), 32'(x.cnt_s));
        check("wrap_flags", 32'({ifw.ovf, ifw.unf, ifw.load_err}), 32'(x.flg_w));
        check("sat_flags",  32'({ifs.ovf, ifs.unf, ifs.load_err}), 32'(x.flg_s));
        check("wrap_tc",    32'(ifw.tc), 32'(x.tc_w));
        check("sat_tc",     32'(ifs.tc), 32'(x.tc_s));
      end
    end
  end

  initial begin
    logic [15:0] edge_vals [5];
    logic e, u, c, l;
    logic [15:0] lv;
    int r;
    edge_vals[0] = 16'h9999; edge_vals[1] = 16'h0000; edge_vals[2] = 16'h9998;
    edge_vals[3] = 16'h0001; edge_vals[4] = 16'h9FFF;

    ifw.en = 1'b1; ifw.up = 1'b1; ifw.clr = 1'b0; ifw.load = 1'b0; ifw.load_val = '0;
    ifs.en = 1'b1; ifs.up = 1'b1; ifs.clr = 1'b0; ifs.load = 1'b0; ifs.load_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_count_w", 32'(ifw.count), 32'h0);
    check("reset_count_s", 32'(ifs.count), 32'h0);
    check("reset_flags_w", 32'({ifw.ovf, ifw.unf, ifw.load_err}), 32'h0);
    check("reset_flags_s", 32'({ifs.ovf, ifs.unf, ifs.load_err}), 32'h0);

    // Up-count 0001..0012 with the 0009->0010 carry.
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

    // Upper limit: wrap to 0000 vs hold at 9999, both pulse ovf.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

    // Lower limit: saturating copy sticks at 0000 with repeated unf.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

    // tc follows a change of up before any clock edge.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    #1;
    check("tc_follow_up_w", 32'(ifw.tc), 32'(tc_ref(pw, 1'b1)));
    check("tc_follow_up_s", 32'(ifs.tc), 32'(tc_ref(ps, 1'b1)));
    @(posedge clk);

    // Priority clr > load > en, then clamped load and a hold cycle.
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h3A7F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

    // Borrow chain and immediate direction reversal.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

    // Asynchronous reset mid-cycle while counting at 0456.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0455);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_count_w", 32'(ifw.count), 32'h0);
    check("async_rst_count_s", 32'(ifs.count), 32'h0);
    mw = 0;
    ms = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

    // Randomized traffic, biased towards the limits.
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 15));
      c  = (r == 0);
      l  = (r == 1 || r == 2);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : edge_vals[$urandom_range(0, 4)];
      step(e, u, c, l, lv);
    end

    #2;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
